// File: rtl/sim_console_pkg.sv
// Shared constants for the simulation console: register byte offsets,
// run-control states and STATUS bit positions.
package sim_console_pkg;

    localparam logic [3:0] TXDATA_OFS = 4'h0;
    localparam logic [3:0] STATUS_OFS = 4'h4;
    localparam logic [3:0] HALT_OFS   = 4'h8;
    localparam logic [3:0] CYCLE_OFS  = 4'hC;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int ST_FULL_BIT  = 0;
    localparam int ST_EMPTY_BIT = 1;
    localparam int ST_HALT_BIT  = 2;
    localparam int ST_CNT_LSB   = 8;

endpackage

// File: rtl/sim_console_fifo.sv
// Byte FIFO for console characters; registered head (no fall-through),
// power-of-two depth so pointers wrap naturally.
module sim_console_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push_i,
    input  logic [7:0]                    wdata_i,
    input  logic                          pop_i,
    output logic [7:0]                    rdata_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(FIFO_DEPTH):0]   count_o
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    // Head reads as 0 when empty so the port is clean out of reset.
    assign rdata_o = empty_o ? 8'h00 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (do_pop && !do_push) count_q <= count_q - 1'b1;
        end
    end

endmodule

// File: rtl/sim_console.sv
// Simulation console / run-control responder: register decode, response
// register, RUN/DRAIN/DONE FSM. Optional cycle counter under SIM_CONSOLE_CYCLE_EN.
module sim_console
    import sim_console_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [3:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              char_valid,
    output logic [7:0]        char_data,
    input  logic              char_ready,
    output logic              halted,
    output logic [7:0]        exit_code,
    output logic              done
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    state_e            state_q, state_d;
    logic [7:0]        exit_q, exit_d;
    logic              rsp_valid_q;
    logic [DATA_W-1:0] rsp_rdata_q, rd_data;
    logic              fifo_full, fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [3:0]        ofs;
    logic              accept, push, halt_wr;
    logic              unused_ok;

    assign ofs       = {req_addr[3:2], 2'b00};
    assign unused_ok = ^{req_addr[1:0], req_wdata[DATA_W-1:8]};

    // Only a TXDATA write into a full FIFO stalls; everything else is accepted.
    assign req_ready = !(req_valid && req_we && (ofs == TXDATA_OFS) && fifo_full);
    assign accept    = req_valid && req_ready;
    assign push      = accept && req_we && (ofs == TXDATA_OFS) && (state_q == RUN);
    assign halt_wr   = accept && req_we && (ofs == HALT_OFS);

    sim_console_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (req_wdata[7:0]),
        .pop_i   (char_valid && char_ready),
        .rdata_o (char_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign char_valid = !fifo_empty;

`ifdef SIM_CONSOLE_CYCLE_EN
    logic [31:0] cyc_q;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                 cyc_q <= '0;
        else if (state_q != DONE) cyc_q <= cyc_q + 32'd1;
    end
`endif

    always_comb begin
        rd_data = '0;
        if (!req_we) begin
            case (ofs)
                STATUS_OFS: begin
                    rd_data[ST_FULL_BIT]         = fifo_full;
                    rd_data[ST_EMPTY_BIT]        = fifo_empty;
                    rd_data[ST_HALT_BIT]         = (state_q != RUN);
                    rd_data[ST_CNT_LSB +: CW]    = fifo_count;
                end
`ifdef SIM_CONSOLE_CYCLE_EN
                CYCLE_OFS: rd_data = DATA_W'(cyc_q);
`else
                CYCLE_OFS: rd_data = '0;
`endif
                default: rd_data = '0;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        exit_d  = exit_q;
        case (state_q)
            RUN: if (halt_wr) begin
                state_d = DRAIN;
                exit_d  = req_wdata[7:0];
            end
            DRAIN:   if (fifo_empty) state_d = DONE;
            DONE:    state_d = DONE;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            exit_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            exit_q      <= exit_d;
            rsp_valid_q <= accept;
            rsp_rdata_q <= accept ? rd_data : '0;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign halted    = (state_q != RUN);
    assign done      = (state_q == DONE);
    assign exit_code = exit_q;

endmodule

// File: tb/tb_sim_console.sv
// Self-checking bench for sim_console: directed vector table, hand-written
// halt/drain/reset sequences, and randomized traffic against a queue model.
module tb_sim_console;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0, char_ready = 1'b0;
    logic [3:0]  req_addr = 4'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_ready, rsp_valid, char_valid, halted, done;
    logic [31:0] rsp_rdata;
    logic [7:0]  char_data, exit_code;

    sim_console #(.FIFO_DEPTH(DEPTH), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .char_valid(char_valid),
        .char_data(char_data), .char_ready(char_ready), .halted(halted),
        .exit_code(exit_code), .done(done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: character queue plus run-control flags.
    logic [7:0]  q[$];
    bit          m_halt, m_done, m_rspv, m_rsp_cyc;
    logic [7:0]  m_exit;
    logic [31:0] m_rdata;
    int unsigned m_cyc;

    task automatic model_reset();
        q.delete();
        m_halt = 0; m_done = 0; m_rspv = 0; m_rsp_cyc = 0;
        m_exit = 0; m_rdata = 0; m_cyc = 0;
    endtask

    function automatic logic [31:0] mread(input logic [1:0] idx);
        logic [31:0] r;
        r = 32'h0;
        if (idx == 2'd1) begin
            r[0]    = (q.size() == DEPTH);
            r[1]    = (q.size() == 0);
            r[2]    = m_halt;
            r[15:8] = 8'(q.size());
        end
`ifdef SIM_CONSOLE_CYCLE_EN
        if (idx == 2'd3) r = m_cyc;
`endif
        return r;
    endfunction

    logic        s_ready, s_rspv, s_cv, s_halt, s_done;
    logic [31:0] s_rdata;
    logic [7:0]  s_cd, s_exit;

    // One bus cycle: drive at negedge, check against model, advance model at posedge.
    task automatic step(input logic v, input logic we, input logic [3:0] a,
                        input logic [31:0] wd, input logic cr);
        bit exp_ready, acc, npop, npush, nhalt, nrspv, ncyc, ndone;
        logic [31:0] nrdata;
        int diff;
        @(negedge clk);
        req_valid = v; req_we = we; req_addr = a; req_wdata = wd; char_ready = cr;
        #1;
        s_ready = req_ready; s_rspv = rsp_valid; s_rdata = rsp_rdata; s_cv = char_valid;
        s_cd = char_data; s_halt = halted; s_exit = exit_code; s_done = done;
        exp_ready = !(v && we && a[3:2] == 2'd0 && q.size() == DEPTH);
        chk("req_ready", s_ready, exp_ready);
        chk("rsp_valid", s_rspv, m_rspv);
        if (m_rsp_cyc) begin
            diff = int'(s_rdata) - int'(m_rdata);
            chk("rsp_cycle_window", (diff >= -2 && diff <= 2), 1);
        end else chk("rsp_rdata", s_rdata, m_rdata);
        chk("char_valid", s_cv, q.size() > 0);
        if (q.size() > 0) chk("char_data", s_cd, q[0]);
        chk("halted", s_halt, m_halt);
        chk("exit_code", s_exit, m_exit);
        chk("done", s_done, m_done);
        acc    = v && exp_ready;
        npop   = (q.size() > 0) && cr;
        npush  = acc && we && a[3:2] == 2'd0 && !m_halt;
        nhalt  = acc && we && a[3:2] == 2'd2 && !m_halt;
        nrspv  = acc;
        nrdata = (acc && !we) ? mread(a[3:2]) : 32'h0;
        ncyc   = acc && !we && a[3:2] == 2'd3;
        ndone  = m_done || (m_halt && q.size() == 0);
        @(posedge clk);
        if (npop) void'(q.pop_front());
        if (npush) q.push_back(wd[7:0]);
        if (!m_done) m_cyc++;
        if (nhalt) begin m_halt = 1; m_exit = wd[7:0]; end
        m_done = ndone; m_rspv = nrspv; m_rdata = nrdata; m_rsp_cyc = ncyc;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; char_ready = 0;
        rst = 0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_char_valid", char_valid, 0);
        chk("rst_char_data", char_data, 0);
        chk("rst_halted", halted, 0);
        chk("rst_exit_code", exit_code, 0);
        chk("rst_done", done, 0);
        chk("rst_req_ready", req_ready, 1);
        repeat (2) @(posedge clk);
        #1 rst = 1;
        model_reset();
    endtask

    typedef struct {
        logic v, we; logic [3:0] a; logic [7:0] wd; logic cr;
        logic e_ready, e_rspv; logic [31:0] e_rdata; logic e_cv; logic [7:0] e_cd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic we, input logic [3:0] a,
                                input logic [7:0] wd, input logic cr, input logic er,
                                input logic ev, input logic [31:0] ed, input logic ec,
                                input logic [7:0] ecd);
        vec_t t;
        t.v = v; t.we = we; t.a = a; t.wd = wd; t.cr = cr;
        t.e_ready = er; t.e_rspv = ev; t.e_rdata = ed; t.e_cv = ec; t.e_cd = ecd;
        return t;
    endfunction

    vec_t vt[20];

    initial begin
        // v we addr data cr | ready rspv rdata cv cd  (outputs seen in that cycle)
        vt[0]  = mk(1,0,4'h4,8'h00,0, 1,0,32'h0,  0,8'h00);
        vt[1]  = mk(1,1,4'h0,8'h41,1, 1,1,32'h2,  0,8'h00);
        vt[2]  = mk(1,1,4'h0,8'h42,1, 1,1,32'h0,  1,8'h41);
        vt[3]  = mk(1,1,4'h0,8'h43,1, 1,1,32'h0,  1,8'h42);
        vt[4]  = mk(0,0,4'h0,8'h00,1, 1,1,32'h0,  1,8'h43);
        vt[5]  = mk(0,0,4'h0,8'h00,0, 1,0,32'h0,  0,8'h00);
        for (int i = 0; i < 8; i++)
            vt[6+i] = mk(1,1,4'h0,8'(8'h10+i),0, 1,(i!=0),32'h0, (i!=0),(i!=0)?8'h10:8'h00);
        vt[14] = mk(1,1,4'h0,8'h18,0, 0,1,32'h0,  1,8'h10);
        vt[15] = mk(1,0,4'h4,8'h00,0, 1,0,32'h0,  1,8'h10);
        vt[16] = mk(1,1,4'h0,8'h18,1, 0,1,32'h801,1,8'h10);
        vt[17] = mk(1,1,4'h0,8'h18,0, 1,0,32'h0,  1,8'h11);
        vt[18] = mk(1,0,4'h4,8'h00,0, 1,1,32'h0,  1,8'h11);
        vt[19] = mk(0,0,4'h0,8'h00,0, 1,1,32'h801,1,8'h11);

        do_reset();
        foreach (vt[i]) begin
            step(vt[i].v, vt[i].we, vt[i].a, {24'h0, vt[i].wd}, vt[i].cr);
            chk($sformatf("vec%0d_ready", i), s_ready, vt[i].e_ready);
            chk($sformatf("vec%0d_rspv", i), s_rspv, vt[i].e_rspv);
            chk($sformatf("vec%0d_rdata", i), s_rdata, vt[i].e_rdata);
            chk($sformatf("vec%0d_cvalid", i), s_cv, vt[i].e_cv);
            if (vt[i].e_cv) chk($sformatf("vec%0d_cdata", i), s_cd, vt[i].e_cd);
        end

        // Halt with two bytes queued; exit code sticks; done after drain.
        do_reset();
        step(1,1,4'h0,32'h61,0);
        step(1,1,4'h0,32'h62,0);
        step(1,1,4'h8,32'h05,0);
        chk("halt_not_yet", s_halt, 0);
        step(0,0,4'h0,32'h0,0);
        chk("halt_rise", s_halt, 1);
        chk("halt_exit", s_exit, 8'h05);
        step(1,1,4'h8,32'h09,0);
        step(0,0,4'h0,32'h0,1);
        chk("halt_exit_sticky", s_exit, 8'h05);
        step(0,0,4'h0,32'h0,1);
        step(0,0,4'h0,32'h0,1);
        chk("done_not_yet", s_done, 0);
        step(1,1,4'h0,32'h77,0);
        chk("done_rise", s_done, 1);
        step(1,0,4'h4,32'h0,0);
        chk("done_tx_dropped", s_cv, 0);
        step(0,0,4'h0,32'h0,0);
        chk("done_status", s_rdata, 32'h6);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        step(1,1,4'h0,32'h71,0);
        step(1,1,4'h0,32'h72,0);
        step(1,1,4'h8,32'h03,0);
        @(negedge clk);
        req_valid = 0; req_we = 0; char_ready = 0;
        chk("pre_rst_halted", halted, 1);
        rst = 0;
        #1;
        chk("mid_rst_char_valid", char_valid, 0);
        chk("mid_rst_halted", halted, 0);
        chk("mid_rst_exit", exit_code, 0);
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        @(posedge clk);
        #1 rst = 1;
        model_reset();
        step(1,0,4'h4,32'h0,0);
        step(0,0,4'h0,32'h0,0);
        chk("post_rst_status", s_rdata, 32'h2);

        // Cycle counter read after ~100 cycles.
        do_reset();
        repeat (100) step(0,0,4'h0,32'h0,0);
        step(1,0,4'hC,32'h0,0);
        step(0,0,4'h0,32'h0,0);
`ifdef SIM_CONSOLE_CYCLE_EN
        chk("cycle_window", (s_rdata >= 32'd98 && s_rdata <= 32'd102), 1);
`else
        chk("cycle_zero", s_rdata, 32'h0);
`endif

        // Randomized traffic; HALT writes kept rare so most time is in RUN.
        for (int ep = 0; ep < 4; ep++) begin
            do_reset();
            for (int n = 0; n < 300; n++) begin
                logic v, we, cr;
                logic [3:0] a;
                v  = ($urandom % 4) != 0;
                we = $urandom % 2;
                a  = 4'($urandom);
                if (we && a[3:2] == 2'd2 && ($urandom % 24) != 0) a[3:2] = 2'd0;
                cr = (ep % 2 == 0) ? (($urandom % 3) != 0) : (($urandom % 4) == 0);
                step(v, we, a, $urandom, cr);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sim_console.md
# sim_console

Memory-mapped simulation console and run-control responder sitting on the CPU data bus beside `main`. It gives the CPU the other direction of run control: the CPU reports characters and a halt/exit code, and the testbench drains characters and ends the run on `done`. Bytes written by the CPU pass through an internal FIFO to a valid/ready character port. The block also holds the run state machine (RUN, DRAIN, DONE).

## Interface
- `FIFO_DEPTH`, 8, character FIFO entries; power of two, at least 2
- `DATA_W`, 32, bus data width
- `clk`  in  1  clock, rising edge
- `rst`  in  1  asynchronous, active-low reset
- `req_valid`  in  1  CPU bus request valid
- `req_ready`  out  1  request accepted when high with `req_valid`
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  4  byte address; bits [3:2] select register, bits [1:0] ignored
- `req_wdata`  in  DATA_W  write data
- `rsp_valid`  out  1  one-cycle response pulse, for reads and writes
- `rsp_rdata`  out  DATA_W  read data; 0 for writes
- `char_valid`  out  1  FIFO head is valid
- `char_data`  out  8  FIFO head byte
- `char_ready`  in  1  testbench consumes the head
- `halted`  out  1  CPU has written HALT
- `exit_code`  out  8  code latched by the first HALT write
- `done`  out  1  halted and FIFO empty

## Operation
- Register map:
  - 0x0 TXDATA: write only; pushes `req_wdata[7:0]`.
  - 0x4 STATUS: read only; bit0 = FIFO full, bit1 = FIFO empty, bit2 = halted, bits[15:8] = FIFO count.
  - 0x8 HALT: write only; `exit_code <= req_wdata[7:0]`, moves to DRAIN.
  - 0xC CYCLE: read only; see Configuration.
- Request acceptance:
  - `req_ready` is combinational.
  - It is low only for a TXDATA write while the FIFO is full. It is high otherwise, including when `req_valid` is low.
- Accepted requests of any kind get exactly one `rsp_valid` pulse.
- Reads of write-only registers return 0. Writes to read-only registers are ignored.
- State machine:
  - RUN → DRAIN on an accepted HALT write.
  - DRAIN → DONE when the FIFO is empty. This is checked every cycle in DRAIN, so it can happen the cycle after entry.
  - DONE is terminal until reset.
- In DRAIN and DONE:
  - TXDATA writes are accepted and responded to, but their data is dropped.
  - Further HALT writes are ignored; the first exit code sticks.
- Outputs by state: `halted` = state != RUN; `done` = state == DONE.
- FIFO behaviour:
  - Pop happens when `char_valid && char_ready`.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - No fall-through: a byte pushed into an empty FIFO appears on `char_valid` the next cycle.
  - Pointers wrap modulo `FIFO_DEPTH`. Count is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: `rsp_valid` 0, `rsp_rdata` 0, `char_valid` 0, `char_data` 0, `halted` 0, `exit_code` 0, `done` 0, FIFO empty, state RUN, cycle counter 0.
- Response latency: an accept in cycle N gives `rsp_valid` in cycle N+1. The CPU accepts every response; there is no response backpressure.
- Back-to-back requests are allowed: one accept per cycle, with responses pipelined one cycle behind.
- STATUS reads the state registered before any same-cycle push or pop.
- `halted` rises the cycle after the HALT accept.
- `done` rises the cycle after the FIFO becomes empty while in DRAIN.
- `char_valid` and `char_data` are stable while `char_ready` is low.
- Reset mid-operation clears the FIFO and any pending response immediately. Queued bytes are lost.

## Configuration
- `SIM_CONSOLE_CYCLE_EN` defined:
  - A 32-bit free-running cycle counter counts from reset and wraps at 2^32.
  - It freezes when state reaches DONE.
  - CYCLE reads return its value.
- Macro undefined: no counter logic; CYCLE reads return 0.

## Structure
- Package `sim_console_pkg` holds:
  - register offset constants: `TXDATA_OFS`, `STATUS_OFS`, `HALT_OFS`, `CYCLE_OFS`
  - state enum: `RUN`, `DRAIN`, `DONE`
  - STATUS bit position constants
- One sub-module, `sim_console_fifo`: synchronous FIFO with parameter `FIFO_DEPTH` and outputs full, empty and count.
- The top level holds decode, the response register, the FSM and the counter.

## Test plan
- Reset, then read STATUS → `rsp_rdata` = 0x0000_0002 one cycle after accept; all other outputs 0.
- Write 0x41, 0x42, 0x43 to TXDATA with `char_ready` = 1 → `char_data` shows 0x41, 0x42, 0x43 in order, one per cycle, starting the cycle after the first push.
- `char_ready` = 0:
  - Write 8 bytes, then a ninth → `req_ready` low for the ninth write; STATUS reads full with count 8.
  - Raise `char_ready` for one cycle → the ninth write is accepted.
- Write 0x05 to HALT with 2 bytes queued:
  - `halted` rises next cycle; `exit_code` = 5.
  - Later HALT of 0x09 → `exit_code` stays 5.
  - `done` rises after both bytes drain.
- Assert reset mid-drain → FIFO empty, `halted` 0, `exit_code` 0, `char_valid` 0 immediately.
- CYCLE read:
  - With `SIM_CONSOLE_CYCLE_EN`, read after 100 cycles → value in 100±2.
  - Without the macro → 0.
